// File: rtl/exception_sequencer_pkg.sv
// Shared types and default constants for the exception sequencer.
package exception_sequencer_pkg;

    localparam int unsigned XLEN    = 16;
    localparam int unsigned NUM_EVT = 4;

    // Pending/grant bit positions, highest priority at bit 0
    localparam int unsigned EVT_SPART     = 0;
    localparam int unsigned EVT_ILL_PC    = 1;
    localparam int unsigned EVT_ILL_MEM   = 2;
    localparam int unsigned EVT_BAD_INSTR = 3;

    // Events that count as faults (everything except SPART receive)
    localparam logic [NUM_EVT-1:0] FAULT_MASK = 4'b1110;

    localparam logic [XLEN-1:0] SPART_VEC_DEF  = 16'h0030;
    localparam logic [XLEN-1:0] PC_VEC_DEF     = 16'h0000;
    localparam logic [XLEN-1:0] MEM_VEC_DEF    = 16'h0100;
    localparam logic [XLEN-1:0] INSTR_VEC_DEF  = 16'h0000;
    localparam logic [XLEN-1:0] DFAULT_VEC_DEF = 16'h0200;
    localparam int unsigned     DRAIN_MAX_DEF  = 8;

    // Event sources as seen in one cycle; bit layout matches EVT_* positions
    typedef struct packed {
        logic bad_instr;
        logic ill_mem;
        logic ill_pc;
        logic spart;
    } evt_t;

    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_SPART     = 3'd1,
        CAUSE_ILL_PC    = 3'd2,
        CAUSE_ILL_MEM   = 3'd3,
        CAUSE_BAD_INSTR = 3'd4,
        CAUSE_DFAULT    = 3'd5
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } state_e;

endpackage

// File: rtl/exception_sequencer_if.sv
// Event, drain and fetch-redirect signals between the core and the exception sequencer.
interface exception_sequencer_if;
    import exception_sequencer_pkg::*;

    logic            evt_spart;
    logic            evt_ill_pc;
    logic            evt_ill_mem;
    logic            evt_bad_instr;
    logic [XLEN-1:0] fault_pc;
    logic            pipe_empty;
    logic            eret;
    logic            redir_ack;

    logic            flush;
    logic            redir_vld;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] epc;
    logic [2:0]      cause;
    logic            kernel;
    logic            double_fault;

    // Core side: raises events, consumes redirects
    modport master (
        output evt_spart, evt_ill_pc, evt_ill_mem, evt_bad_instr,
        output fault_pc, pipe_empty, eret, redir_ack,
        input  flush, redir_vld, redir_pc, epc, cause, kernel, double_fault
    );

    // Sequencer side
    modport slave (
        input  evt_spart, evt_ill_pc, evt_ill_mem, evt_bad_instr,
        input  fault_pc, pipe_empty, eret, redir_ack,
        output flush, redir_vld, redir_pc, epc, cause, kernel, double_fault
    );

endinterface

// File: rtl/exception_sequencer_exc_priority_enc.sv
// Fixed-priority pick among pending events: one-hot grant plus matching cause code.
module exc_priority_enc
    import exception_sequencer_pkg::*;
(
    input  logic [NUM_EVT-1:0] pending,
    output logic [NUM_EVT-1:0] grant,
    output cause_e             cause,
    output logic               any
);

    // SPART beats every fault; faults ordered pc, mem, instr
    always_comb begin
        grant = '0;
        cause = CAUSE_NONE;
        any   = |pending;
        if (pending[EVT_SPART]) begin
            grant[EVT_SPART] = 1'b1;
            cause            = CAUSE_SPART;
        end else if (pending[EVT_ILL_PC]) begin
            grant[EVT_ILL_PC] = 1'b1;
            cause             = CAUSE_ILL_PC;
        end else if (pending[EVT_ILL_MEM]) begin
            grant[EVT_ILL_MEM] = 1'b1;
            cause              = CAUSE_ILL_MEM;
        end else if (pending[EVT_BAD_INSTR]) begin
            grant[EVT_BAD_INSTR] = 1'b1;
            cause                = CAUSE_BAD_INSTR;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry/exit sequencer: latches events, drains the pipe, redirects fetch, restores EPC on ERET.
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] SPART_VEC  = SPART_VEC_DEF,
    parameter logic [XLEN-1:0] PC_VEC     = PC_VEC_DEF,
    parameter logic [XLEN-1:0] MEM_VEC    = MEM_VEC_DEF,
    parameter logic [XLEN-1:0] INSTR_VEC  = INSTR_VEC_DEF,
    parameter logic [XLEN-1:0] DFAULT_VEC = DFAULT_VEC_DEF,
    parameter int unsigned     DRAIN_MAX  = DRAIN_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    exception_sequencer_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(DRAIN_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

    state_e               state_q, state_d;
    logic [NUM_EVT-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]      epc_q, epc_d;
    cause_e               cause_q, cause_d;
    logic                 kernel_q, kernel_d;
    logic                 dfault_q, dfault_d;
    logic                 flush_q, flush_d;
    logic                 redir_vld_q, redir_vld_d;
    logic [XLEN-1:0]      redir_pc_q, redir_pc_d;

    evt_t                 evt_in;
    logic [NUM_EVT-1:0]   new_evt;
    logic [NUM_EVT-1:0]   grant;
    cause_e               win_cause;
    logic                 pend_any;

    function automatic logic [XLEN-1:0] vector_of(input cause_e c);
        case (c)
            CAUSE_SPART:     vector_of = SPART_VEC;
            CAUSE_ILL_PC:    vector_of = PC_VEC;
            CAUSE_ILL_MEM:   vector_of = MEM_VEC;
            CAUSE_BAD_INSTR: vector_of = INSTR_VEC;
            CAUSE_DFAULT:    vector_of = DFAULT_VEC;
            default:         vector_of = '0;
        endcase
    endfunction

    // SPART receive is dropped (not queued) while privileged
    assign evt_in.spart     = bus.evt_spart & ~kernel_q;
    assign evt_in.ill_pc    = bus.evt_ill_pc;
    assign evt_in.ill_mem   = bus.evt_ill_mem;
    assign evt_in.bad_instr = bus.evt_bad_instr;
    assign new_evt          = evt_in;

    exc_priority_enc u_prio (
        .pending (pending_q),
        .grant   (grant),
        .cause   (win_cause),
        .any     (pend_any)
    );

    // Next-state and next-output computation
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | new_evt;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        kernel_d  = kernel_q;
        dfault_d  = dfault_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_any) begin
                    state_d   = ST_DRAIN;
                    pending_d = (pending_q & ~grant) | new_evt;
                    epc_d     = bus.fault_pc;
                    cause_d   = win_cause;
                    cnt_d     = '0;
                end else if (kernel_q && bus.eret) begin
                    // Out of reset the core runs privileged boot code; its ERET enters user mode
                    state_d = ST_RETURN;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.pipe_empty || (cnt_q == CNT_LAST)) begin
                    state_d = ST_VECTOR;
                end
            end
            ST_VECTOR: begin
                if (bus.redir_ack) begin
                    kernel_d = 1'b1;
                    state_d  = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (bus.eret) begin
                    state_d = ST_RETURN;
                end else if (|(new_evt & FAULT_MASK)) begin
                    // Fresh fault inside the handler: consumed as a double fault, EPC preserved
                    state_d   = ST_DRAIN;
                    pending_d = pending_q | (new_evt & ~FAULT_MASK);
                    dfault_d  = 1'b1;
                    cause_d   = CAUSE_DFAULT;
                    cnt_d     = '0;
                end
            end
            ST_RETURN: begin
                if (bus.redir_ack) begin
                    kernel_d = 1'b0;
                    cause_d  = CAUSE_NONE;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush covers the IDLE cycle that commits to entry as well as every DRAIN cycle
        flush_d     = (state_d == ST_DRAIN) || ((state_d == ST_IDLE) && (|pending_d));
        redir_vld_d = (state_d == ST_VECTOR) || (state_d == ST_RETURN);
        redir_pc_d  = '0;
        if (state_d == ST_VECTOR) begin
            redir_pc_d = vector_of(cause_d);
        end else if (state_d == ST_RETURN) begin
            redir_pc_d = epc_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            cnt_q       <= '0;
            epc_q       <= '0;
            cause_q     <= CAUSE_NONE;
            kernel_q    <= 1'b1;
            dfault_q    <= 1'b0;
            flush_q     <= 1'b0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            kernel_q    <= kernel_d;
            dfault_q    <= dfault_d;
            flush_q     <= flush_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign bus.flush        = flush_q;
    assign bus.redir_vld    = redir_vld_q;
    assign bus.redir_pc     = redir_pc_q;
    assign bus.epc          = epc_q;
    assign bus.cause        = cause_q;
    assign bus.kernel       = kernel_q;
    assign bus.double_fault = dfault_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: entry, priority, masking, drain timeout, double fault, reset.
module tb_exception_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    exception_sequencer_if bus();

    exception_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic m, input logic b);
        bus.evt_spart     = s;
        bus.evt_ill_pc    = p;
        bus.evt_ill_mem   = m;
        bus.evt_bad_instr = b;
        tick();
        bus.evt_spart     = 1'b0;
        bus.evt_ill_pc    = 1'b0;
        bus.evt_ill_mem   = 1'b0;
        bus.evt_bad_instr = 1'b0;
    endtask

    task automatic do_eret();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    // Waits (bounded) for a redirect, then acknowledges it for one cycle
    task automatic do_ack(input string tag);
        int n = 0;
        while (bus.redir_vld !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        if (bus.redir_vld !== 1'b1) expect_eq({tag, "_vld_timeout"}, 32'(bus.redir_vld), 32'd1);
        bus.redir_ack = 1'b1;
        tick();
        bus.redir_ack = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        expect_eq({tag, "_flush"},  32'(bus.flush),        32'd0);
        expect_eq({tag, "_vld"},    32'(bus.redir_vld),    32'd0);
        expect_eq({tag, "_pc"},     32'(bus.redir_pc),     32'h0);
        expect_eq({tag, "_epc"},    32'(bus.epc),          32'h0);
        expect_eq({tag, "_cause"},  32'(bus.cause),        32'd0);
        expect_eq({tag, "_kernel"}, 32'(bus.kernel),       32'd1);
        expect_eq({tag, "_dfault"}, 32'(bus.double_fault), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n             = 1'b0;
        bus.evt_spart     = 1'b0;
        bus.evt_ill_pc    = 1'b0;
        bus.evt_ill_mem   = 1'b0;
        bus.evt_bad_instr = 1'b0;
        bus.fault_pc      = 16'h0000;
        bus.pipe_empty    = 1'b1;
        bus.eret          = 1'b0;
        bus.redir_ack     = 1'b0;

        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: boot code ERET drops to user mode at address 0
        expect_eq("t1_kernel_boot", 32'(bus.kernel), 32'd1);
        do_eret();
        expect_eq("t1_ret_vld", 32'(bus.redir_vld), 32'd1);
        expect_eq("t1_ret_pc",  32'(bus.redir_pc),  32'h0);
        expect_eq("t1_ret_epc", 32'(bus.epc),       32'h0);
        bus.redir_ack = 1'b1; tick(); bus.redir_ack = 1'b0;
        expect_eq("t1_kernel",  32'(bus.kernel),    32'd0);
        expect_eq("t1_cause",   32'(bus.cause),     32'd0);
        expect_eq("t1_vld_off", 32'(bus.redir_vld), 32'd0);

        // 2: illegal memory access in user mode, pipe already empty
        bus.fault_pc = 16'h1234;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_eq("t2_flush_n1", 32'(bus.flush),     32'd1);
        expect_eq("t2_vld_n1",   32'(bus.redir_vld), 32'd0);
        tick();
        expect_eq("t2_flush_n2", 32'(bus.flush),     32'd1);
        expect_eq("t2_epc",      32'(bus.epc),       32'h1234);
        expect_eq("t2_cause",    32'(bus.cause),     32'd3);
        expect_eq("t2_vld_n2",   32'(bus.redir_vld), 32'd0);
        tick();
        expect_eq("t2_vld_n3",   32'(bus.redir_vld), 32'd1);
        expect_eq("t2_vec",      32'(bus.redir_pc),  32'h0100);
        expect_eq("t2_flush_n3", 32'(bus.flush),     32'd0);
        tick(2);
        expect_eq("t2_vld_hold", 32'(bus.redir_vld), 32'd1);
        expect_eq("t2_pc_hold",  32'(bus.redir_pc),  32'h0100);
        bus.redir_ack = 1'b1; tick(); bus.redir_ack = 1'b0;
        expect_eq("t2_kernel_h", 32'(bus.kernel),    32'd1);
        expect_eq("t2_vld_h",    32'(bus.redir_vld), 32'd0);
        do_eret();
        expect_eq("t2_ret_pc",   32'(bus.redir_pc),  32'h1234);
        do_ack("t2_ret");
        expect_eq("t2_kernel_u", 32'(bus.kernel),    32'd0);
        expect_eq("t2_cause_u",  32'(bus.cause),     32'd0);

        // 3: SPART and bad instruction together; SPART first, bad instruction after return
        bus.fault_pc = 16'h2000;
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        expect_eq("t3_cause_a", 32'(bus.cause), 32'd1);
        expect_eq("t3_epc_a",   32'(bus.epc),   32'h2000);
        tick();
        expect_eq("t3_vec_a",   32'(bus.redir_pc), 32'h0030);
        do_ack("t3_vec_a");
        do_eret();
        expect_eq("t3_ret_pc",  32'(bus.redir_pc), 32'h2000);
        bus.fault_pc = 16'h2004;
        do_ack("t3_ret");
        expect_eq("t3_kernel_u", 32'(bus.kernel), 32'd0);
        expect_eq("t3_flush_b",  32'(bus.flush),  32'd1);
        tick();
        expect_eq("t3_cause_b", 32'(bus.cause), 32'd4);
        expect_eq("t3_epc_b",   32'(bus.epc),   32'h2004);
        tick();
        expect_eq("t3_vld_b",   32'(bus.redir_vld), 32'd1);
        expect_eq("t3_vec_b",   32'(bus.redir_pc),  32'h0000);
        do_ack("t3_vec_b");

        // 4: SPART while privileged is dropped
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_eq("t4_flush_a", 32'(bus.flush), 32'd0);
        tick();
        expect_eq("t4_flush_b", 32'(bus.flush),     32'd0);
        expect_eq("t4_vld",     32'(bus.redir_vld), 32'd0);
        expect_eq("t4_cause",   32'(bus.cause),     32'd4);
        expect_eq("t4_kernel",  32'(bus.kernel),    32'd1);

        // ERET and a fault in the same handler cycle: ERET wins, fault taken afterwards
        bus.fault_pc    = 16'h2008;
        bus.eret        = 1'b1;
        bus.evt_ill_mem = 1'b1;
        tick();
        bus.eret        = 1'b0;
        bus.evt_ill_mem = 1'b0;
        expect_eq("t4e_ret_vld", 32'(bus.redir_vld),    32'd1);
        expect_eq("t4e_ret_pc",  32'(bus.redir_pc),     32'h2004);
        expect_eq("t4e_dfault",  32'(bus.double_fault), 32'd0);
        do_ack("t4e_ret");
        expect_eq("t4e_flush",   32'(bus.flush),  32'd1);
        tick();
        expect_eq("t4e_cause",   32'(bus.cause),  32'd3);
        expect_eq("t4e_epc",     32'(bus.epc),    32'h2008);
        tick();
        expect_eq("t4e_vec",     32'(bus.redir_pc), 32'h0100);
        do_ack("t4e_vec");
        do_eret();
        do_ack("t4e_ret2");
        expect_eq("t4e_kernel_u", 32'(bus.kernel), 32'd0);
        expect_eq("t4e_idle",     32'(bus.flush),  32'd0);

        // 5: pipe never empties; vector forced after DRAIN_MAX drain cycles
        bus.pipe_empty = 1'b0;
        bus.fault_pc   = 16'h3000;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_eq("t5_flush_drain", 32'(bus.flush), 32'd1);
        n = 0;
        while (bus.redir_vld !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        expect_eq("t5_drain_len", 32'(n),             32'd8);
        expect_eq("t5_vec",       32'(bus.redir_pc),  32'h0000);
        expect_eq("t5_cause",     32'(bus.cause),     32'd2);
        expect_eq("t5_epc",       32'(bus.epc),       32'h3000);
        bus.pipe_empty = 1'b1;
        do_ack("t5_vec");

        // 6: fault inside the handler is a double fault; then reset mid-drain
        bus.fault_pc = 16'h4444;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        expect_eq("t6_dfault", 32'(bus.double_fault), 32'd1);
        expect_eq("t6_cause",  32'(bus.cause),        32'd5);
        expect_eq("t6_flush",  32'(bus.flush),        32'd1);
        expect_eq("t6_epc",    32'(bus.epc),          32'h3000);
        tick();
        expect_eq("t6_vld",    32'(bus.redir_vld),    32'd1);
        expect_eq("t6_vec",    32'(bus.redir_pc),     32'h0200);
        do_ack("t6_vec");
        bus.pipe_empty = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_eq("t6_in_drain", 32'(bus.flush), 32'd1);
        rst_n = 1'b0;
        #2;
        check_reset_values("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.pipe_empty = 1'b1;
        tick(3);
        expect_eq("t6_post_flush",  32'(bus.flush),        32'd0);
        expect_eq("t6_post_vld",    32'(bus.redir_vld),    32'd0);
        expect_eq("t6_post_dfault", 32'(bus.double_fault), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
